// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue controller: FSM states,
// opcode values and the bit positions of the 16-bit instruction fields.
package alu_issue_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DECODE    = 2'd1,
    EXECUTE   = 2'd2,
    WRITEBACK = 2'd3
  } state_e;

  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 9;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 3;
  localparam int IMM_LSB = 0;

  // opcode[3] selects the immediate form of opcode[2:0]
  localparam int IMM_FORM_BIT = 3;

  localparam logic [3:0] OPC_ADD = 4'h0;
  localparam logic [3:0] OPC_SUB = 4'h1;
  localparam logic [3:0] OPC_AND = 4'h2;
  localparam logic [3:0] OPC_OR  = 4'h3;
  localparam logic [3:0] OPC_XOR = 4'h4;
  localparam logic [3:0] OPC_SHL = 4'h5;
  localparam logic [3:0] OPC_SHR = 4'h6;
  localparam logic [3:0] OPC_MUL = 4'h7;
  localparam logic [3:0] OPC_NOP = 4'hF;

  function automatic logic is_nop(input logic [3:0] opc);
    return opc == OPC_NOP;
  endfunction

endpackage

// File: rtl/imm_sign_extender.sv
// Sign-extends an IN_WIDTH immediate to OUT_WIDTH.
// Purely combinational, zero latency, no flow control.
module imm_sign_extender #(
  parameter int IN_WIDTH  = 6,
  parameter int OUT_WIDTH = 16
) (
  input  logic [IN_WIDTH-1:0]  imm_i,
  output logic [OUT_WIDTH-1:0] imm_o
);

  assign imm_o = {{(OUT_WIDTH-IN_WIDTH){imm_i[IN_WIDTH-1]}}, imm_i};

endmodule

// File: rtl/alu_issue_controller.sv
// Issues one instruction at a time through DECODE/EXECUTE/WRITEBACK.
// Latency: 4 cycles accept-to-ready (3 for NOP); ready is high only in IDLE.
// Optional ALU_MULTICYCLE_EN: MUL holds EXECUTE until in_alu_done.
module alu_issue_controller
  import alu_issue_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int IMM_WIDTH      = 6,
  parameter int REG_ADDR_WIDTH = 3
) (
  input  logic                      in_clk,
  input  logic                      in_rst,
  input  logic                      in_instr_valid,
  input  logic [15:0]               in_instruction,
  output logic                      out_instr_ready,
  output logic [REG_ADDR_WIDTH-1:0] out_rs1_addr,
  output logic [REG_ADDR_WIDTH-1:0] out_rs2_addr,
  output logic [DATA_WIDTH-1:0]     out_immediate,
  output logic                      out_sel_operand_2,
  output logic [3:0]                out_alu_op,
  output logic                      out_alu_start,
  input  logic                      in_alu_done,
  output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
  output logic                      out_reg_write,
  output logic                      out_busy
);

  state_e      state_q, state_d;
  logic [15:0] instr_q;
  logic        exec_first_q;

  logic [3:0]            opcode;
  logic                  nop;
  logic                  active;
  logic                  exec_hold;
  logic [DATA_WIDTH-1:0] imm_ext;

  assign opcode = instr_q[OPC_LSB +: 4];
  assign nop    = is_nop(opcode);
  assign active = (state_q != IDLE);

`ifdef ALU_MULTICYCLE_EN
  assign exec_hold = (opcode == OPC_MUL) && !in_alu_done;
`else
  logic unused_alu_done;
  assign unused_alu_done = in_alu_done;
  assign exec_hold       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (in_instr_valid) state_d = DECODE;
      DECODE:    state_d = EXECUTE;
      EXECUTE: begin
        if (nop)            state_d = IDLE;
        else if (!exec_hold) state_d = WRITEBACK;
      end
      WRITEBACK: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q      <= IDLE;
      instr_q      <= '0;
      exec_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      exec_first_q <= (state_q == DECODE);
      if (state_q == IDLE && in_instr_valid) instr_q <= in_instruction;
    end
  end

  imm_sign_extender #(
    .IN_WIDTH  (IMM_WIDTH),
    .OUT_WIDTH (DATA_WIDTH)
  ) u_imm_ext (
    .imm_i (instr_q[IMM_LSB +: IMM_WIDTH]),
    .imm_o (imm_ext)
  );

  // Decode outputs come from the latched word and are forced to 0 in IDLE.
  assign out_rs1_addr      = active ? instr_q[RS1_LSB +: REG_ADDR_WIDTH] : '0;
  assign out_rs2_addr      = active ? instr_q[RS2_LSB +: REG_ADDR_WIDTH] : '0;
  assign out_rd_addr       = active ? instr_q[RD_LSB  +: REG_ADDR_WIDTH] : '0;
  assign out_immediate     = active ? imm_ext : '0;
  assign out_sel_operand_2 = active && !nop && opcode[IMM_FORM_BIT];
  assign out_alu_op        = (active && !nop) ? {1'b0, opcode[2:0]} : 4'd0;

  assign out_alu_start   = (state_q == EXECUTE) && exec_first_q && !nop;
  assign out_reg_write   = (state_q == WRITEBACK);
  assign out_instr_ready = (state_q == IDLE);
  assign out_busy        = active;

endmodule
